// File: rtl/mem_arb_pkg.sv
// Shared FSM encoding and default sizing for the memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 64;
    localparam int DEPTH_DEF  = 1000;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        DRAIN  = 2'd1,
        LOCKED = 2'd2
    } arb_state_e;

    // Plain-vector aliases of the state encoding for legacy-style state registers
    localparam logic [1:0] ST_ARB    = ARB;
    localparam logic [1:0] ST_DRAIN  = DRAIN;
    localparam logic [1:0] ST_LOCKED = LOCKED;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus of the memory port arbiter: per-requester request payload plus shared response.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_we;
    logic [NREQ-1:0][ADDR_W-1:0] req_addr;
    logic [NREQ-1:0][DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0]             resp_valid;
    logic [DATA_W-1:0]           resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin picker: one-hot grant to the first requester after last_grant, wrapping N-1 to 0.
module rr_pick #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] last_grant,
    output logic [N-1:0]     grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = PTR_W'((int'(last_grant) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port array arbiter with round-robin sharing and a host lock (ARB -> DRAIN -> LOCKED).
// Optional address range checking is enabled with `define MEM_ARB_RANGE_CHECK_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               host_lock,
    output logic               host_owned,
    mem_port_arbiter_if.slave  bus,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata
`ifdef MEM_ARB_RANGE_CHECK_EN
    ,
    output logic               range_err
`endif
);

    localparam int               PTR_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(NREQ - 1);

    if (longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_depth_check
        $error("mem_port_arbiter: DEPTH exceeds the address space");
    end

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [PTR_W-1:0]  last_ptr;
    logic [NREQ-1:0]   rr_grant;
    logic [NREQ-1:0]   grant;
    logic [PTR_W-1:0]  sel_idx;
    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              addr_oob;
    logic [NREQ-1:0]   resp_valid_q;

    rr_pick #(
        .N     (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req        (bus.req_valid),
        .last_grant (last_ptr),
        .grant      (rr_grant)
    );

    // Nothing is accepted while reset is held, so a read in that cycle never produces a response
    always_comb begin
        grant = '0;
        if (rst_n) begin
            case (state)
                ST_ARB:    if (!host_lock) grant = rr_grant;
                ST_LOCKED: grant[0] = bus.req_valid[0];
                default:   grant = '0;
            endcase
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) sel_idx = PTR_W'(i);
        end
    end

    assign accept    = |grant;
    assign sel_we    = bus.req_we[sel_idx];
    assign sel_addr  = bus.req_addr[sel_idx];
    assign sel_wdata = bus.req_wdata[sel_idx];

`ifdef MEM_ARB_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic rd_oob_q;

    assign addr_oob  = ({1'b0, sel_addr} >= DEPTH_L);
    assign range_err = accept && addr_oob;
`else
    assign addr_oob  = 1'b0;
`endif

    assign bus.req_ready = grant;
    assign mem_we        = accept && sel_we && !addr_oob;
    assign mem_addr      = sel_addr;
    assign mem_wdata     = sel_wdata;

    // Ownership is signalled from the drain cycle on; requester 0 is served once LOCKED
    assign host_owned = (state != ST_ARB);

    always_comb begin
        state_nx = state;
        case (state)
            ST_ARB:    if (host_lock) state_nx = ST_DRAIN;
            ST_DRAIN:  state_nx = host_lock ? ST_LOCKED : ST_ARB;
            ST_LOCKED: if (!host_lock) state_nx = ST_ARB;
            default:   state_nx = ST_ARB;
        endcase
    end

    // Only round-robin grants move the pointer; locked host accesses leave the rotation intact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_ARB;
            last_ptr     <= PTR_RESET;
            resp_valid_q <= '0;
        end else begin
            state        <= state_nx;
            resp_valid_q <= grant & {NREQ{!sel_we}};
            if (state == ST_ARB && accept) last_ptr <= sel_idx;
        end
    end

    assign bus.resp_valid = resp_valid_q;

`ifdef MEM_ARB_RANGE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_oob_q <= 1'b0;
        else        rd_oob_q <= accept && !sel_we && addr_oob;
    end

    assign bus.resp_rdata = rd_oob_q ? '0 : mem_rdata;
`else
    assign bus.resp_rdata = mem_rdata;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a reference arbiter model and response scoreboard.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;

    typedef struct packed {
        logic [NREQ-1:0]   who;
        logic [DATA_W-1:0] data;
    } resp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              host_lock = 1'b0;
    logic              host_owned;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
`ifdef MEM_ARB_RANGE_CHECK_EN
    logic              range_err;
`endif

    mem_port_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .NREQ   (NREQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (1000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_lock  (host_lock),
        .host_owned (host_owned),
        .bus        (bus),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef MEM_ARB_RANGE_CHECK_EN
        ,
        .range_err  (range_err)
`endif
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem_array [1024];
    logic [DATA_W-1:0] ref_mem   [1024];
    logic [DATA_W-1:0] rd_tmp;

    // Synchronous-read array attached to the memory port
    always @(posedge clk) begin
        rd_tmp = mem_array[mem_addr];
        if (mem_we) mem_array[mem_addr] = mem_wdata;
        mem_rdata <= rd_tmp;
    end

    function automatic logic [DATA_W-1:0] pattern(input int i);
        return {32'hA5A5_0000, 32'(i)};
    endfunction

    int                           checks = 0;
    int                           errors = 0;
    logic [1:0]                   m_state;
    int                           m_last;
    resp_t                        exp_q[$];
    logic [NREQ-1:0][ADDR_W-1:0]  a_drv;
    logic [NREQ-1:0][DATA_W-1:0]  d_drv;

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_state = ST_ARB;
        m_last  = NREQ - 1;
        exp_q.delete();
    endtask

    // Drive one cycle, check every output against the model, then advance the model past the edge
    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ-1:0] w, input logic lock);
        logic [NREQ-1:0] exp_grant;
        logic            oob;
        int              g;
        int              k;
        resp_t           e;

        @(negedge clk);
        bus.req_valid = v;
        bus.req_we    = w;
        bus.req_addr  = a_drv;
        bus.req_wdata = d_drv;
        host_lock     = lock;
        #1;

        exp_grant = '0;
        g         = 0;
        oob       = 1'b0;
        if (m_state == ST_ARB && !lock) begin
            for (int i = 1; i <= NREQ; i++) begin
                k = (m_last + i) % NREQ;
                if (exp_grant == '0 && v[k]) exp_grant[k] = 1'b1;
            end
        end else if (m_state == ST_LOCKED) begin
            exp_grant[0] = v[0];
        end
        for (int i = 0; i < NREQ; i++) if (exp_grant[i]) g = i;
`ifdef MEM_ARB_RANGE_CHECK_EN
        if (exp_grant != '0) oob = (int'(a_drv[g]) >= 1000);
        checkOutput("range_err", 64'(range_err), 64'(exp_grant != '0 && oob));
`endif

        checkOutput("req_ready", 64'(bus.req_ready), 64'(exp_grant));
        checkOutput("host_owned", 64'(host_owned), 64'(m_state != ST_ARB));
        if (exp_grant != '0) begin
            checkOutput("mem_we", 64'(mem_we), 64'(w[g] && !oob));
            checkOutput("mem_addr", 64'(mem_addr), 64'(a_drv[g]));
            if (w[g]) checkOutput("mem_wdata", mem_wdata, d_drv[g]);
        end else begin
            checkOutput("mem_we_idle", 64'(mem_we), 64'd0);
        end

        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("resp_valid", 64'(bus.resp_valid), 64'(e.who));
            checkOutput("resp_rdata", bus.resp_rdata, e.data);
        end else begin
            checkOutput("resp_valid_idle", 64'(bus.resp_valid), 64'd0);
        end

        if (exp_grant != '0) begin
            if (m_state == ST_ARB) m_last = g;
            if (w[g]) begin
                if (!oob) ref_mem[a_drv[g]] = d_drv[g];
            end else begin
                e.who  = exp_grant;
                e.data = oob ? '0 : ref_mem[a_drv[g]];
                exp_q.push_back(e);
            end
        end
        case (m_state)
            ST_ARB:    if (lock) m_state = ST_DRAIN;
            ST_DRAIN:  m_state = lock ? ST_LOCKED : ST_ARB;
            default:   if (!lock) m_state = ST_ARB;
        endcase
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        a_drv         = '0;
        d_drv         = '0;
        for (int i = 0; i < 1024; i++) begin
            mem_array[i] = pattern(i);
            ref_mem[i]   = pattern(i);
        end

        // Reads presented while reset is held must not be served
        a_drv         = {10'd3, 10'd2, 10'd1};
        bus.req_addr  = a_drv;
        bus.req_valid = 3'b111;
        @(negedge clk);
        #1;
        checkOutput("rst_host_owned", 64'(host_owned), 64'd0);
        checkOutput("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        checkOutput("rst_mem_we", 64'(mem_we), 64'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.req_valid = '0;
        modelReset();

        // All three read continuously: rotation 0,1,2,0
        for (int i = 0; i < 4; i++) applyStimulus(3'b111, 3'b000, 1'b0);
        applyStimulus(3'b000, 3'b000, 1'b0);
        applyStimulus(3'b000, 3'b000, 1'b0);

        // Requester 1 writes -5 to address 7, requester 2 reads it back
        a_drv    = {10'd7, 10'd7, 10'd4};
        d_drv[1] = -64'sd5;
        applyStimulus(3'b010, 3'b010, 1'b0);
        applyStimulus(3'b100, 3'b000, 1'b0);
        applyStimulus(3'b000, 3'b000, 1'b0);

        // Contention with a mix of reads and writes
        a_drv = {10'd12, 10'd11, 10'd10};
        d_drv = {64'h2222, 64'h1111, 64'h0};
        applyStimulus(3'b111, 3'b110, 1'b0);
        applyStimulus(3'b111, 3'b110, 1'b0);
        applyStimulus(3'b111, 3'b000, 1'b0);
        applyStimulus(3'b111, 3'b000, 1'b0);
        applyStimulus(3'b000, 3'b000, 1'b0);

        // Host lock raised the cycle after a read; requester 1 waits out the lock
        a_drv = {10'd20, 10'd21, 10'd5};
        applyStimulus(3'b001, 3'b000, 1'b0);
        applyStimulus(3'b011, 3'b000, 1'b1);
        applyStimulus(3'b011, 3'b000, 1'b1);
        applyStimulus(3'b011, 3'b000, 1'b1);
        applyStimulus(3'b010, 3'b000, 1'b1);
        applyStimulus(3'b010, 3'b000, 1'b0);
        applyStimulus(3'b010, 3'b000, 1'b0);
        applyStimulus(3'b000, 3'b000, 1'b0);

        // Lock dropped during the drain cycle goes straight back to arbitration
        applyStimulus(3'b000, 3'b000, 1'b1);
        applyStimulus(3'b100, 3'b000, 1'b0);
        applyStimulus(3'b100, 3'b000, 1'b0);
        applyStimulus(3'b000, 3'b000, 1'b0);

        // Address 1000 sits past the valid depth
        a_drv    = {10'd1000, 10'd0, 10'd1000};
        d_drv[2] = 64'h5A5A;
        applyStimulus(3'b100, 3'b100, 1'b0);
        applyStimulus(3'b001, 3'b000, 1'b0);
        applyStimulus(3'b000, 3'b000, 1'b0);

        // Reset pulsed while a read response is on the bus
        a_drv = {10'd0, 10'd0, 10'd9};
        applyStimulus(3'b001, 3'b000, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("pre_rst_resp_valid", 64'(bus.resp_valid), 64'd1);
        @(negedge clk);
        rst_n         = 1'b0;
        bus.req_valid = 3'b010;
        bus.req_we    = 3'b010;
        #1;
        checkOutput("mid_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        checkOutput("mid_rst_mem_we", 64'(mem_we), 64'd0);
        checkOutput("mid_rst_host_owned", 64'(host_owned), 64'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.req_valid = '0;
        bus.req_we    = '0;
        modelReset();
        a_drv = {10'd33, 10'd32, 10'd31};
        applyStimulus(3'b111, 3'b000, 1'b0);
        applyStimulus(3'b000, 3'b000, 1'b0);
        applyStimulus(3'b000, 3'b000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
